instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Owns the architectural PC and the instruction-memory request side of fetch.
//  Issues one request per instruction, captures the returned word and presents it to decode as i_fetch.
//  Loads the next_pc value computed by decode when decode accepts the instruction.
//  Sits between the instruction memory port and the decode stage, closing the PC loop.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  TIMEOUT    16             max cycles in FETCH without imem_ack before FAULT (0 = disabled)
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-high
//  next_pc     in   32  next PC from decode, sampled only on accept
//  advance     in   1   decode accepts current i_fetch this cycle
//  imem_req    out  1   instruction memory request
//  imem_addr   out  32  request address, always equal to pc
//  imem_ack    in   1   memory returns imem_rdata this cycle
//  imem_rdata  in   32  instruction word
//  pc          out  32  PC of the instruction being fetched/presented
//  i_fetch     out  32  captured instruction word
//  i_valid     out  1   i_fetch valid for decode
//  halted      out  1   sticky: zero instruction accepted
//  fault       out  1   sticky: misaligned next_pc or memory timeout
// BEHAVIOUR
//  States: FETCH, DELIVER, HALT, FAULT (2-bit encoding). All outputs are registered except imem_addr, which is wired to pc.
//  Reset (async, any state): pc=RESET_PC, state=FETCH, imem_req=1, i_fetch=0, i_valid=0, halted=0, fault=0, wait_cnt=0.
//  FETCH
//   - imem_req=1, imem_addr=pc, held stable until ack.
//   - On imem_ack: i_fetch<=imem_rdata, i_valid<=1, imem_req<=0, then DELIVER.
//   - Best-case latency: ack in the first FETCH cycle -> i_valid high the next cycle.
//   - wait_cnt increments each FETCH cycle without ack.
//   - If wait_cnt reaches TIMEOUT-1 with no ack -> FAULT.
//  DELIVER
//   - i_valid=1 and i_fetch held while advance=0.
//   - On advance, i_fetch==0: -> HALT; halted<=1, i_valid<=0, pc unchanged.
//   - On advance, next_pc[1:0]!=0: -> FAULT; fault<=1, i_valid<=0, pc unchanged.
//   - Otherwise on advance: pc<=next_pc, i_valid<=0, imem_req<=1, wait_cnt<=0, then FETCH.
//   - next_pc==pc is legal and re-fetches the same address.
//  HALT, FAULT: terminal. imem_req=0, i_valid=0, pc frozen; exit only via reset.
//  Ignored inputs:
//   - imem_ack outside FETCH.
//   - advance outside DELIVER.
//   - advance and imem_ack together in FETCH: ack handled, advance ignored.
//  Arithmetic: wait_cnt is $clog2(TIMEOUT+1) bits, saturating. No PC arithmetic here; pc+4 belongs to decode.
//  Reset mid-FETCH: imem_req stays 1 and imem_addr goes to RESET_PC immediately; memory must tolerate the abandoned request.
// STRUCTURE
//  Shared include fetch_defs.vh holds:
//   - FETCH/DELIVER/HALT/FAULT state encodings
//   - the HALT_INSTR=32'h0 constant, shared with decode's halt detection
//  One sub-module, fetch_timeout_ctr (param TIMEOUT; ports clk, reset, clr, en, expired); the FSM stays in this module.
// TESTING
//  1 Reset, RESET_PC=0, ack in first cycle with rdata=0x2408_0005
//    -> imem_addr=0; cycle 2 i_valid=1, i_fetch=0x2408_0005.
//  2 Ack delayed 3 cycles -> imem_req/imem_addr stable all 4 cycles; i_valid only after ack.
//  3 DELIVER, advance=1, next_pc=0x0000_0040 -> next cycle pc=0x40, imem_req=1, i_valid=0.
//  4 Hold advance=0 for 5 cycles -> i_fetch unchanged, no new request.
//  5 rdata=0 then advance
//    -> halted=1, imem_req=0 forever; further acks ignored; pc frozen at halting address.
//  6 next_pc=0x0000_0046 on advance -> fault=1, pc unchanged.
//  7 TIMEOUT=16, no ack -> fault=1 on 16th FETCH cycle.
//  8 Assert reset during FETCH -> all outputs reset immediately, no clock edge required.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//  - fetch_state_e : FSM state encodings (FETCH, DELIVER, HALT, FAULT), 2 bits
//  - HALT_INSTR    : instruction word that halts the machine (also used by decode)
//  - pc_misaligned : helper flagging a PC that is not word aligned
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DELIVER = 2'd1,
    ST_HALT    = 2'd2,
    ST_FAULT   = 2'd3
  } fetch_state_e;

  localparam logic [31:0] HALT_INSTR = 32'h0000_0000;

  // A PC must be word aligned; any set bit in [1:0] is a fault.
  function automatic logic pc_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory port bundle between the fetch unit and instruction memory.
//  imem_req   : request valid (fetch -> memory)
//  imem_addr  : request address (fetch -> memory)
//  imem_ack   : read data valid this cycle (memory -> fetch)
//  imem_rdata : instruction word (memory -> fetch)
// master = fetch side, slave = memory side.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit_timeout_ctr.sv
// Saturating wait counter for the fetch unit's memory-response timeout.
//  clk     : clock, rising edge
//  reset   : asynchronous, active-high
//  clr     : zero the counter (wins over en)
//  en      : count one cycle without a memory response
//  expired : registered; high while the count equals TIMEOUT-1 (never when TIMEOUT==0)
module fetch_timeout_ctr
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 32'd1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'((TIMEOUT > 32'd0) ? (TIMEOUT - 32'd1) : 32'd0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic ENABLED         = (TIMEOUT > 32'd0) ? 1'b1 : 1'b0;
  // With TIMEOUT==1 a cleared counter is already at its limit.
  localparam logic EXPIRED_AT_ZERO = (TIMEOUT == 32'd1) ? 1'b1 : 1'b0;

  logic [CNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0] wait_cnt_s;
  logic             expired_r;

  // Next count: clear has priority, otherwise saturating increment.
  always_comb begin
    wait_cnt_s = wait_cnt_r;
    if (clr) begin
      wait_cnt_s = {CNT_W{1'b0}};
    end else if (en && (wait_cnt_r != CNT_MAX)) begin
      wait_cnt_s = wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_s = wait_cnt_r;
    end
  end

  // Count register; expired is registered from the next count so it always
  // mirrors (wait_cnt_r == LIMIT) without a combinational compare on the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= {CNT_W{1'b0}};
      expired_r  <= EXPIRED_AT_ZERO;
    end else begin
      wait_cnt_r <= wait_cnt_s;
      expired_r  <= ENABLED && (wait_cnt_s == LIMIT);
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the architectural PC, issues one instruction
// memory request per instruction, captures the returned word and presents it
// to decode; loads decode's next_pc when decode accepts the instruction.
//  clk      : clock, rising edge
//  reset    : asynchronous, active-high
//  next_pc  : next PC from decode, sampled only when advance is accepted
//  advance  : decode accepts the presented instruction
//  imem     : instruction memory port (master side)
//  pc       : PC of the instruction being fetched/presented
//  i_fetch  : captured instruction word
//  i_valid  : i_fetch valid for decode
//  halted   : sticky, a halt instruction was accepted
//  fault    : sticky, misaligned next_pc or memory timeout
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                next_pc,
  input  logic                       advance,
  instr_fetch_unit_if.master         imem,
  output logic [31:0]                pc,
  output logic [31:0]                i_fetch,
  output logic                       i_valid,
  output logic                       halted,
  output logic                       fault
);

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic [31:0]  i_fetch_r;
  logic         i_valid_r;
  logic         imem_req_r;
  logic         halted_r;
  logic         fault_r;

  logic         tmo_en_s;
  logic         tmo_clr_s;
  logic         tmo_expired_s;

  // The counter only runs while waiting in FETCH; any response or leaving
  // FETCH zeroes it, so every new fetch starts from a clean count.
  assign tmo_en_s  = (state_r == ST_FETCH) && !imem.imem_ack;
  assign tmo_clr_s = (state_r != ST_FETCH) || imem.imem_ack;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmo_clr_s),
    .en      (tmo_en_s),
    .expired (tmo_expired_s)
  );

  // Fetch FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_FETCH;
      pc_r       <= RESET_PC;
      imem_req_r <= 1'b1;
      i_fetch_r  <= 32'h0000_0000;
      i_valid_r  <= 1'b0;
      halted_r   <= 1'b0;
      fault_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          // A response wins over a timeout landing in the same cycle.
          if (imem.imem_ack) begin
            i_fetch_r  <= imem.imem_rdata;
            i_valid_r  <= 1'b1;
            imem_req_r <= 1'b0;
            state_r    <= ST_DELIVER;
          end else if (tmo_expired_s) begin
            fault_r    <= 1'b1;
            imem_req_r <= 1'b0;
            state_r    <= ST_FAULT;
          end else begin
            imem_req_r <= 1'b1;
          end
        end
        ST_DELIVER: begin
          if (advance) begin
            i_valid_r <= 1'b0;
            if (i_fetch_r == HALT_INSTR) begin
              halted_r <= 1'b1;
              state_r  <= ST_HALT;
            end else if (pc_misaligned(next_pc)) begin
              fault_r <= 1'b1;
              state_r <= ST_FAULT;
            end else begin
              pc_r       <= next_pc;
              imem_req_r <= 1'b1;
              state_r    <= ST_FETCH;
            end
          end else begin
            i_valid_r <= 1'b1;
          end
        end
        ST_HALT: begin
          imem_req_r <= 1'b0;
          i_valid_r  <= 1'b0;
        end
        ST_FAULT: begin
          imem_req_r <= 1'b0;
          i_valid_r  <= 1'b0;
        end
        default: begin
          // Unreachable encoding: park in FAULT rather than guess.
          imem_req_r <= 1'b0;
          i_valid_r  <= 1'b0;
          fault_r    <= 1'b1;
          state_r    <= ST_FAULT;
        end
      endcase
    end
  end

  // imem_addr is wired straight to pc so it tracks reset without a clock edge.
  assign imem.imem_addr = pc_r;
  assign imem.imem_req  = imem_req_r;
  assign pc             = pc_r;
  assign i_fetch        = i_fetch_r;
  assign i_valid        = i_valid_r;
  assign halted         = halted_r;
  assign fault          = fault_r;

endmodule
